// File: rtl/ppi_seq_pkg.sv
// rtl/ppi_seq_pkg.sv - shared types and constants for the PPI bus sequencer
package ppi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } ppi_state_e;

  localparam logic [1:0] PPI_ADDR_A    = 2'd0;
  localparam logic [1:0] PPI_ADDR_B    = 2'd1;
  localparam logic [1:0] PPI_ADDR_C    = 2'd2;
  localparam logic [1:0] PPI_ADDR_CTRL = 2'd3;

  localparam logic [7:0] PPI_CTRL_RESET = 8'h7F;
  localparam int         PPI_BSR_BIT    = 7;

endpackage

// File: rtl/ppi_bus_sequencer_if.sv
// rtl/ppi_bus_sequencer_if.sv - request/response and PPI bus signal bundle
interface ppi_bus_sequencer_if;

  logic       req0_valid;
  logic       req0_ready;
  logic       req0_wr;
  logic [1:0] req0_addr;
  logic [7:0] req0_wdata;

  logic       req1_valid;
  logic       req1_ready;
  logic       req1_wr;
  logic [1:0] req1_addr;
  logic [7:0] req1_wdata;

  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_rdata;

  logic       ppi_cs_n;
  logic       ppi_rd_n;
  logic       ppi_wr_n;
  logic [1:0] ppi_addr;
  logic [7:0] ppi_d_out;
  logic       ppi_d_oe;
  logic [7:0] ppi_d_in;

  logic [7:0] ctrl_shadow;

  // Sequencer side.
  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    input  ppi_d_in,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_rdata,
    output ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_addr, ppi_d_out, ppi_d_oe,
    output ctrl_shadow
  );

  // Fabric / PPI-device side.
  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    output ppi_d_in,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_rdata,
    input  ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_addr, ppi_d_out, ppi_d_oe,
    input  ctrl_shadow
  );

endinterface

// File: rtl/ppi_rr_arb2.sv
// rtl/ppi_rr_arb2.sv - two-way round-robin arbiter
module ppi_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester granted last; reset to 1 so req0 wins the first tie.
  logic last;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// rtl/ppi_bus_sequencer.sv - arbitrated CS/RD/WR cycle sequencer for an 8255-style PPI
// Optional PPI_BSR_CMD_EN: BSR writes to the control port are sent as {1,000,wdata[3:0]}.
module ppi_bus_sequencer
  import ppi_seq_pkg::*;
#(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 2,
  parameter int T_HOLD   = 1,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  ppi_bus_sequencer_if.slave bus
);

  ppi_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic       lat_id;
  logic       lat_wr;
  logic [1:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [7:0] rdata;
  logic [7:0] shadow;
  logic [7:0] bus_wdata;

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       in_idle;
  logic       in_bus;
  logic       in_strobe;
  logic       accept;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign in_idle   = (state == IDLE);
  assign accept    = in_idle && (grant != 2'b00);

  ppi_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (req_valid),
    .advance (in_idle),
    .grant   (grant)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (T_SETUP > 0) begin
            state_nxt = SETUP;
            cnt_nxt   = CNT_W'(T_SETUP - 1);
          end else begin
            state_nxt = STROBE;
            cnt_nxt   = CNT_W'(T_STROBE - 1);
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = CNT_W'(T_STROBE - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          if (T_HOLD > 0) begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_W'(T_HOLD - 1);
          end else begin
            state_nxt = RESP;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_id    <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= PPI_ADDR_A;
      lat_wdata <= 8'h00;
      rdata     <= 8'h00;
      shadow    <= PPI_CTRL_RESET;
    end else begin
      if (accept) begin
        lat_id    <= grant[1];
        lat_wr    <= grant[1] ? bus.req1_wr    : bus.req0_wr;
        lat_addr  <= grant[1] ? bus.req1_addr  : bus.req0_addr;
        lat_wdata <= grant[1] ? bus.req1_wdata : bus.req0_wdata;
        rdata     <= 8'h00;
      end
      if (in_strobe && (cnt == '0) && !lat_wr) begin
        rdata <= bus.ppi_d_in;
      end
      // Only mode-set words are mirrored; BSR writes leave the mode untouched.
      if ((state_nxt == RESP) && (state != RESP) && lat_wr &&
          (lat_addr == PPI_ADDR_CTRL) && !lat_wdata[PPI_BSR_BIT]) begin
        shadow <= lat_wdata;
      end
    end
  end

`ifdef PPI_BSR_CMD_EN
  assign bus_wdata = ((lat_addr == PPI_ADDR_CTRL) && lat_wdata[PPI_BSR_BIT]) ?
                     {1'b1, 3'b000, lat_wdata[3:0]} : lat_wdata;
`else
  assign bus_wdata = lat_wdata;
`endif

  // Bus outputs decode straight from state so an async reset drops them at once.
  assign in_bus    = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign in_strobe = (state == STROBE);

  assign bus.req0_ready  = accept && grant[0];
  assign bus.req1_ready  = accept && grant[1];
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = lat_id;
  assign bus.rsp_rdata   = rdata;
  assign bus.ppi_cs_n    = !in_bus;
  assign bus.ppi_rd_n    = !(in_strobe && !lat_wr);
  assign bus.ppi_wr_n    = !(in_strobe && lat_wr);
  assign bus.ppi_d_oe    = in_bus && lat_wr;
  assign bus.ppi_addr    = in_bus ? lat_addr : PPI_ADDR_A;
  assign bus.ppi_d_out   = (in_bus && lat_wr) ? bus_wdata : 8'h00;
  assign bus.ctrl_shadow = shadow;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// tb/tb_ppi_bus_sequencer.sv - scoreboard bench for ppi_bus_sequencer
module tb_ppi_bus_sequencer;

  localparam int TS  = 1;
  localparam int TST = 2;
  localparam int TH  = 1;
  localparam int LAT = TS + TST + TH + 1;
`ifdef PPI_BSR_CMD_EN
  localparam bit BSR_EN = 1'b1;
`else
  localparam bit BSR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ppi_bus_sequencer_if bus ();
  ppi_bus_sequencer_if bus2 ();

  ppi_bus_sequencer #(.T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  ppi_bus_sequencer #(.T_SETUP(0), .T_STROBE(1), .T_HOLD(0), .CNT_W(4)) dut_fast (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // PPI device pin model: each port returns a fixed pattern.
  logic [7:0] pins [4];
  assign bus.ppi_d_in  = pins[bus.ppi_addr];
  assign bus2.ppi_d_in = 8'h5A;

  function automatic logic [7:0] exp_bus_data(input logic [1:0] a, input logic [7:0] d);
    if (BSR_EN && (a == 2'd3) && d[7]) return {4'h8, d[3:0]};
    return d;
  endfunction

  typedef struct {
    logic       id;
    logic [7:0] rdata;
    int         due;
    logic [7:0] shadow;
  } exp_t;
  exp_t q[$];

  // Reference model: a transaction occupies LAT+1 cycles from its accept cycle.
  bit         m_act;
  int         m_acc;
  int         m_k;
  logic       m_last;
  logic       m_wr;
  logic [1:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_shadow;
  logic [1:0] m_grant;
  logic       m_inbus;
  logic       m_strobe;
  logic [13:0] m_exp_bus;
  exp_t       e_new;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_act    = 1'b0;
      m_last   = 1'b1;
      m_shadow = 8'h7F;
    end else begin
      m_k = cyc - m_acc;
      if (m_act && (m_k > LAT)) m_act = 1'b0;
      m_inbus  = m_act && (m_k >= 1) && (m_k <= TS + TST + TH);
      m_strobe = m_act && (m_k > TS) && (m_k <= TS + TST);
      m_exp_bus = {~m_inbus, ~(m_strobe & ~m_wr), ~(m_strobe & m_wr), m_inbus & m_wr,
                   m_inbus ? m_addr : 2'b00,
                   (m_inbus & m_wr) ? exp_bus_data(m_addr, m_data) : 8'h00};
      chk("bus_pins", {bus.ppi_cs_n, bus.ppi_rd_n, bus.ppi_wr_n, bus.ppi_d_oe,
                       bus.ppi_addr, bus.ppi_d_out}, m_exp_bus);
      m_grant = 2'b00;
      if (!m_act) begin
        if (bus.req0_valid && bus.req1_valid) m_grant = m_last ? 2'b01 : 2'b10;
        else m_grant = {bus.req1_valid, bus.req0_valid};
      end
      chk("ready", {bus.req1_ready, bus.req0_ready}, m_grant);
      if (m_grant != 2'b00) begin
        m_last = m_grant[1];
        m_wr   = m_grant[1] ? bus.req1_wr    : bus.req0_wr;
        m_addr = m_grant[1] ? bus.req1_addr  : bus.req0_addr;
        m_data = m_grant[1] ? bus.req1_wdata : bus.req0_wdata;
        if (m_wr && (m_addr == 2'd3) && !m_data[7]) m_shadow = m_data;
        m_act  = 1'b1;
        m_acc  = cyc;
        e_new.id     = m_grant[1];
        e_new.rdata  = m_wr ? 8'h00 : pins[m_addr];
        e_new.due    = cyc + LAT;
        e_new.shadow = m_shadow;
        q.push_back(e_new);
      end
    end
  end

  exp_t e_pop;
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
    end else if (bus.rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e_pop = q.pop_front();
        chk("rsp_id", bus.rsp_id, e_pop.id);
        chk("rsp_rdata", bus.rsp_rdata, e_pop.rdata);
        chk("rsp_latency", cyc, e_pop.due);
        chk("ctrl_shadow", bus.ctrl_shadow, e_pop.shadow);
      end
    end else if ((q.size() > 0) && (cyc > q[0].due)) begin
      chk("rsp_timeout", cyc, q[0].due);
      void'(q.pop_front());
    end
  end

  task automatic set_req(input int id, input logic v, input logic wr,
                         input logic [1:0] a, input logic [7:0] d);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_wr = wr; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_wr = wr; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic do_req(input int id, input logic wr, input logic [1:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(id, 1'b1, wr, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? bus.req0_ready : bus.req1_ready;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    set_req(id, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    set_req(0, 1'b0, 1'b0, 2'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 2'd0, 8'h00);
    bus2.req0_valid = 1'b0; bus2.req0_wr = 1'b0; bus2.req0_addr = 2'd0; bus2.req0_wdata = 8'h00;
    bus2.req1_valid = 1'b0; bus2.req1_wr = 1'b0; bus2.req1_addr = 2'd0; bus2.req1_wdata = 8'h00;
    pins[0] = 8'h81;
    for (int i = 1; i < 4; i++) pins[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_shadow", bus.ctrl_shadow, 8'h7F);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_rdata}, 10'h000);
    chk("rst_strobes", {bus.ppi_cs_n, bus.ppi_rd_n, bus.ppi_wr_n, bus.ppi_d_oe}, 4'b1110);

    // BSR writes leave the shadow alone.
    do_req(0, 1'b1, 2'd3, 8'h8B);
    do_req(0, 1'b1, 2'd3, 8'hFB);
    drain();
    chk("bsr_shadow", bus.ctrl_shadow, 8'h7F);

    // Mode word then port A read.
    do_req(0, 1'b1, 2'd3, 8'h10);
    do_req(0, 1'b0, 2'd0, 8'h00);
    drain();
    chk("mode_shadow", bus.ctrl_shadow, 8'h10);

    // Both requesters pending for four transactions.
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 2'd1, 8'h00);
    set_req(1, 1'b1, 1'b1, 2'd2, 8'h3C);
    repeat (4 * (LAT + 1)) @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 2'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 2'd0, 8'h00);
    drain();

    // Reset during the second strobe cycle of a write.
    do_req(1, 1'b1, 2'd1, 8'h55);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_wr_n", bus.ppi_wr_n, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_pins", {bus.ppi_cs_n, bus.ppi_wr_n, bus.ppi_d_oe}, 3'b110);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_shadow", bus.ctrl_shadow, 8'h7F);
    do_req(0, 1'b0, 2'd2, 8'h00);
    drain();

    // Random traffic from both requesters.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      set_req(0, 1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 8'($urandom));
      set_req(1, 1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 8'($urandom));
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 2'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 2'd0, 8'h00);
    drain();

    // req1 always pending, req0 flickering.
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'($urandom), 2'($urandom), 8'($urandom));
      set_req(0, 1'(i % 2), 1'b0, 2'd0, 8'h00);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 2'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 2'd0, 8'h00);
    drain();

    // Zero setup/hold, single-cycle strobe.
    bus2.req0_valid = 1'b1; bus2.req0_wr = 1'b0; bus2.req0_addr = 2'd1;
    @(negedge clk);
    chk("fast_ready", bus2.req0_ready, 1'b1);
    @(posedge clk); #1;
    bus2.req0_valid = 1'b0;
    @(negedge clk);
    chk("fast_cs_rd_same", {bus2.ppi_cs_n, bus2.ppi_rd_n, bus2.rsp_valid}, 3'b000);
    @(negedge clk);
    chk("fast_rsp", {bus2.rsp_valid, bus2.rsp_rdata}, 9'h15A);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus2.rsp_valid) seen = 1'b1;
    end
    chk("fast_no_dup", seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
